des_key_schedule: RTL and testbench

DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

---
 rtl/des_key_schedule.sv | 195 +++++++++++++++++++
 tb/tb_des_key_schedule.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/des_key_schedule.sv
// DES key schedule: PC-1 capture, then one rotated/PC-2 round subkey per clock into key1..key16.
// Optional odd-parity checking of the captured key is enabled by defining DES_KS_PARITY_CHECK_EN.
module des_key_schedule (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [0:63] key_in,
  output logic        busy,
  output logic        done,
  output logic        keys_valid,
  output logic [0:47] key1,
  output logic [0:47] key2,
  output logic [0:47] key3,
  output logic [0:47] key4,
  output logic [0:47] key5,
  output logic [0:47] key6,
  output logic [0:47] key7,
  output logic [0:47] key8,
  output logic [0:47] key9,
  output logic [0:47] key10,
  output logic [0:47] key11,
  output logic [0:47] key12,
  output logic [0:47] key13,
  output logic [0:47] key14,
  output logic [0:47] key15,
  output logic [0:47] key16,
  output logic        parity_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // Table entries are 1-based DES bit numbers (bit 1 = MSB = index 0).
  localparam int PC1 [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [0:47] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [0:27] c_q, c_d, d_q, d_d;
  logic [0:47] keys_q [16];
  logic [0:47] keys_d [16];
  logic        keys_valid_q, keys_valid_d;

  logic [0:27] pc1_c, pc1_d;
  logic [0:27] c_rot, d_rot;
  logic [0:55] cd_rot;
  logic [0:47] subkey;
  logic        one_shift;
  logic        accept;

  genvar gi;

  generate
    for (gi = 0; gi < 28; gi++) begin : g_pc1
      assign pc1_c[gi] = key_in[PC1[gi] - 1];
      assign pc1_d[gi] = key_in[PC1[gi + 28] - 1];
    end
  endgenerate

  // Rounds 1, 2, 9 and 16 (counter 0, 1, 8, 15) shift by one; all others by two.
  assign one_shift = (cnt_q == 4'd0) || (cnt_q == 4'd1) || (cnt_q == 4'd8) || (cnt_q == 4'd15);
  assign c_rot     = one_shift ? {c_q[1:27], c_q[0]} : {c_q[2:27], c_q[0:1]};
  assign d_rot     = one_shift ? {d_q[1:27], d_q[0]} : {d_q[2:27], d_q[0:1]};
  assign cd_rot    = {c_rot, d_rot};

  generate
    for (gi = 0; gi < 48; gi++) begin : g_pc2
      assign subkey[gi] = cd_rot[PC2[gi] - 1];
    end
  endgenerate

  assign accept = (state_q == S_IDLE) && start;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    c_d          = c_q;
    d_d          = d_q;
    keys_d       = keys_q;
    keys_valid_d = keys_valid_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          c_d          = pc1_c;
          d_d          = pc1_d;
          cnt_d        = 4'd0;
          keys_valid_d = 1'b0;
          state_d      = S_RUN;
        end
      end
      S_RUN: begin
        c_d           = c_rot;
        d_d           = d_rot;
        keys_d[cnt_q] = subkey;
        if (cnt_q == 4'd15) begin
          keys_valid_d = 1'b1;
          state_d      = S_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      c_q          <= '0;
      d_q          <= '0;
      keys_valid_q <= 1'b0;
      for (int i = 0; i < 16; i++) keys_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      c_q          <= c_d;
      d_q          <= d_d;
      keys_valid_q <= keys_valid_d;
      for (int i = 0; i < 16; i++) keys_q[i] <= keys_d[i];
    end
  end

`ifdef DES_KS_PARITY_CHECK_EN
  logic       parity_err_q, parity_err_d;
  logic [7:0] byte_even;

  generate
    for (gi = 0; gi < 8; gi++) begin : g_par
      assign byte_even[gi] = ~^key_in[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    parity_err_d = parity_err_q;
    if (accept) parity_err_d = |byte_even;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) parity_err_q <= 1'b0;
    else      parity_err_q <= parity_err_d;
  end

  assign parity_err = parity_err_q;
`else
  // Parity bits only feed the optional checker; fold them here so they are accounted for.
  logic unused_parity_bits;
  logic unused_accept;
  assign unused_parity_bits = ^{key_in[7], key_in[15], key_in[23], key_in[31],
                                key_in[39], key_in[47], key_in[55], key_in[63]};
  assign unused_accept      = accept;
  assign parity_err         = 1'b0;
`endif

  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign keys_valid = keys_valid_q;

  assign key1  = keys_q[0];
  assign key2  = keys_q[1];
  assign key3  = keys_q[2];
  assign key4  = keys_q[3];
  assign key5  = keys_q[4];
  assign key6  = keys_q[5];
  assign key7  = keys_q[6];
  assign key8  = keys_q[7];
  assign key9  = keys_q[8];
  assign key10 = keys_q[9];
  assign key11 = keys_q[10];
  assign key12 = keys_q[11];
  assign key13 = keys_q[12];
  assign key14 = keys_q[13];
  assign key15 = keys_q[14];
  assign key16 = keys_q[15];

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule: known-answer schedule, zero-key cases, start hold, mid-run reset.
module tb_des_key_schedule;

  logic        clk;
  logic        rst;
  logic        start;
  logic [0:63] key_in;
  logic        busy, done, keys_valid, parity_err;
  logic [0:47] key1, key2, key3, key4, key5, key6, key7, key8;
  logic [0:47] key9, key10, key11, key12, key13, key14, key15, key16;
  logic [0:47] ks [16];

  int checks = 0;
  int errors = 0;

  localparam logic [0:63] KEY_A  = 64'h133457799BBCDFF1;
  localparam logic [0:63] KEY_01 = 64'h0101010101010101;

  des_key_schedule dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in),
    .busy(busy), .done(done), .keys_valid(keys_valid),
    .key1(key1), .key2(key2), .key3(key3), .key4(key4),
    .key5(key5), .key6(key6), .key7(key7), .key8(key8),
    .key9(key9), .key10(key10), .key11(key11), .key12(key12),
    .key13(key13), .key14(key14), .key15(key15), .key16(key16),
    .parity_err(parity_err)
  );

  assign ks[0]  = key1;   assign ks[1]  = key2;   assign ks[2]  = key3;   assign ks[3]  = key4;
  assign ks[4]  = key5;   assign ks[5]  = key6;   assign ks[6]  = key7;   assign ks[7]  = key8;
  assign ks[8]  = key9;   assign ks[9]  = key10;  assign ks[10] = key11;  assign ks[11] = key12;
  assign ks[12] = key13;  assign ks[13] = key14;  assign ks[14] = key15;  assign ks[15] = key16;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Pulse start for one edge, then wait (bounded) for done; leaves the bench in the done cycle.
  task automatic start_and_wait(input logic [0:63] k, input string tag);
    int lat;
    @(negedge clk);
    key_in = k;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    check_val({tag, "_busy_r1"}, 64'(busy), 64'd1);
    check_val({tag, "_valid_cleared"}, 64'(keys_valid), 64'd0);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_val({tag, "_latency"}, 64'(lat), 64'd16);
    check_val({tag, "_valid_in_done"}, 64'(keys_valid), 64'd1);
    check_val({tag, "_busy_in_done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int pulses;
    rst    = 1'b0;
    start  = 1'b0;
    key_in = '0;
    #1;
    check_val("rst_busy",   64'(busy), 64'd0);
    check_val("rst_done",   64'(done), 64'd0);
    check_val("rst_valid",  64'(keys_valid), 64'd0);
    check_val("rst_parity", 64'(parity_err), 64'd0);
    check_val("rst_key1",   64'(key1), 64'd0);
    check_val("rst_key16",  64'(key16), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Known-answer schedule
    start_and_wait(KEY_A, "kat");
    check_val("kat_key1",  64'(key1),  64'h1B02EFFC7072);
    check_val("kat_key2",  64'(key2),  64'h79AED9DBC9E5);
    check_val("kat_key3",  64'(key3),  64'h55FC8A42CF99);
    check_val("kat_key16", 64'(key16), 64'hCB3D8B0E17F5);
    check_val("kat_parity", 64'(parity_err), 64'd0);
    repeat (3) @(negedge clk);
    check_val("idle_done_low",  64'(done), 64'd0);
    check_val("idle_valid_hold", 64'(keys_valid), 64'd1);
    check_val("idle_key1_hold", 64'(key1), 64'h1B02EFFC7072);

    // Only parity bits set: every subkey must come out zero
    start_and_wait(KEY_01, "par01");
    for (int i = 0; i < 16; i++)
      check_val($sformatf("par01_key%0d", i + 1), 64'(ks[i]), 64'd0);
    check_val("par01_parity", 64'(parity_err), 64'd0);

    // All-zero key: every byte has even parity
    start_and_wait(64'd0, "zero");
    check_val("zero_key9", 64'(key9), 64'd0);
`ifdef DES_KS_PARITY_CHECK_EN
    check_val("zero_parity", 64'(parity_err), 64'd1);
`else
    check_val("zero_parity", 64'(parity_err), 64'd0);
`endif

    // Start held through RUN and DONE with key_in changing every cycle
    @(negedge clk);
    key_in = KEY_A;
    start  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      key_in = {$urandom, $urandom};
      if (done) pulses++;
      if (i == 17) start = 1'b0;
    end
    check_val("hold_pulses", 64'(pulses), 64'd1);
    check_val("hold_busy",   64'(busy), 64'd0);
    check_val("hold_key1",   64'(key1), 64'h1B02EFFC7072);
    check_val("hold_key16",  64'(key16), 64'hCB3D8B0E17F5);

    // Reset during round 8
    @(negedge clk);
    key_in = KEY_A;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check_val("mid_key1_written", 64'(key1), 64'h1B02EFFC7072);
    #2 rst = 1'b0;
    #1;
    check_val("mid_busy",  64'(busy), 64'd0);
    check_val("mid_valid", 64'(keys_valid), 64'd0);
    check_val("mid_key1",  64'(key1), 64'd0);
    check_val("mid_key8",  64'(key8), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check_val("mid_no_done", 64'(pulses), 64'd0);
    start_and_wait(KEY_A, "again");
    check_val("again_key1",  64'(key1),  64'h1B02EFFC7072);
    check_val("again_key16", 64'(key16), 64'hCB3D8B0E17F5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
